// File: rtl/serial_cmp_pkg.sv
// rtl/serial_cmp_pkg.sv - shared state encodings and compare-cell result codes
package serial_cmp_pkg;

    typedef enum logic [1:0] {
        IDLE    = 2'd0,
        COMPARE = 2'd1,
        DONE    = 2'd2
    } state_t;

    // {le, ge} as produced by the 1-bit cell; 2'b00 is unreachable
    localparam logic [1:0] LT = 2'b10;
    localparam logic [1:0] GT = 2'b01;
    localparam logic [1:0] EQ = 2'b11;

    function automatic int cnt_width(input int w);
        return (w > 1) ? $clog2(w) : 1;
    endfunction

endpackage

// File: rtl/bit_le_ge.sv
// rtl/bit_le_ge.sv - 1-bit unsigned compare cell (le = a<=b, ge = a>=b)
module bit_le_ge (
    input  logic a_bit,
    input  logic b_bit,
    output logic le,
    output logic ge
);

    assign le = ~a_bit | b_bit;
    assign ge =  a_bit | ~b_bit;

endmodule

// File: rtl/serial_magnitude_comparator.sv
// rtl/serial_magnitude_comparator.sv - MSB-first bit-serial unsigned comparator with early exit
module serial_magnitude_comparator
    import serial_cmp_pkg::*;
#(
    parameter int WIDTH = 8
) (
    input  logic             clk,
    input  logic             reset,
    input  logic             start,
    input  logic [WIDTH-1:0] a,
    input  logic [WIDTH-1:0] b,
    output logic             busy,
    output logic             done,
    output logic             gt,
    output logic             lt,
    output logic             eq
);

    localparam int              CNT_W   = cnt_width(WIDTH);
    localparam logic [CNT_W-1:0] IDX_TOP = CNT_W'(WIDTH - 1);

    state_t            state;
    state_t            state_nxt;
    logic [WIDTH-1:0]  ra;
    logic [WIDTH-1:0]  rb;
    logic [CNT_W-1:0]  idx;
    logic              cell_le;
    logic              cell_ge;
    logic [1:0]        cell_code;
    logic              gt_q;
    logic              lt_q;
    logic              eq_q;
    logic              accept;
    logic              last_bit;

    bit_le_ge u_cell (
        .a_bit (ra[idx]),
        .b_bit (rb[idx]),
        .le    (cell_le),
        .ge    (cell_ge)
    );

    assign cell_code = {cell_le, cell_ge};
    assign accept    = (state == IDLE) && start;
    assign last_bit  = (idx == '0);

    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            state <= IDLE;
        end else begin
            state <= state_nxt;
        end
    end

    always_comb begin
        state_nxt = state;
        case (state)
            IDLE: begin
                if (start) begin
                    state_nxt = COMPARE;
                end
            end
            COMPARE: begin
                case (cell_code)
                    LT, GT:  state_nxt = DONE;
                    EQ:      state_nxt = last_bit ? DONE : COMPARE;
                    default: state_nxt = COMPARE;
                endcase
            end
            DONE:    state_nxt = IDLE;
            default: state_nxt = IDLE;
        endcase
    end

    always_comb begin
        busy = (state == COMPARE);
        done = (state == DONE);
        gt   = gt_q;
        lt   = lt_q;
        eq   = eq_q;
    end

    // Operands are frozen from the accepted start until the next one; flags hold likewise
    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            ra   <= '0;
            rb   <= '0;
            idx  <= '0;
            gt_q <= 1'b0;
            lt_q <= 1'b0;
            eq_q <= 1'b0;
        end else if (accept) begin
            ra   <= a;
            rb   <= b;
            idx  <= IDX_TOP;
            gt_q <= 1'b0;
            lt_q <= 1'b0;
            eq_q <= 1'b0;
        end else if (state == COMPARE) begin
            case (cell_code)
                LT: lt_q <= 1'b1;
                GT: gt_q <= 1'b1;
                EQ: begin
                    if (last_bit) begin
                        eq_q <= 1'b1;
                    end else begin
                        idx <= idx - 1'b1;
                    end
                end
                default: ;
            endcase
        end
    end

endmodule

// File: doc/serial_magnitude_comparator.md
Name: serial_magnitude_comparator

Overview:
Multi-cycle N-bit unsigned magnitude comparator built on the 1-bit compare cell (le = A≤B, ge = A≥B).
- Captures two operands on a start handshake, then presents one bit pair per cycle to the cell, MSB first.
- Consumes the cell's le/ge outputs and terminates early on the first differing bit.
- Sits directly downstream of the operand source and directly upstream of any control logic that consumes gt/lt/eq.

Parameters:
WIDTH, 8, operand width in bits; legal range ≥1.
CNT_W, derived: max(1, clog2(WIDTH)), bit-index counter width; not user-overridable.

Ports:
clk    input   1      rising-edge clock
reset  input   1      asynchronous, active-high reset
start  input   1      request pulse; sampled only in IDLE
a      input   WIDTH  operand A, captured on the accepted start edge
b      input   WIDTH  operand B, captured on the accepted start edge
busy   output  1      high while in COMPARE
done   output  1      one-cycle pulse; result valid
gt     output  1      A>B; held until the next accepted start
lt     output  1      A<B; held until the next accepted start
eq     output  1      A==B; held until the next accepted start

Behaviour:
- Clock and reset: one clock, clk. reset is asynchronous and active-high. Asserting reset forces state=IDLE and busy=done=gt=lt=eq=0, with the counter and operand registers cleared. This applies mid-operation too: no result is produced for the aborted compare.
- States: IDLE, COMPARE, DONE. Encodings live in the shared package.
- IDLE:
  - start=1 at an edge captures a→ra and b→rb, sets idx=WIDTH-1, clears gt/lt/eq, and moves to COMPARE.
  - start=0 stays in IDLE.
- COMPARE (busy=1):
  - Cell inputs are ra[idx] and rb[idx]. The cell is purely combinational, so le and ge are valid in the same cycle.
  - le=1, ge=0: register lt=1, go to DONE.
  - le=0, ge=1: register gt=1, go to DONE.
  - le=1, ge=1 (bits equal) with idx==0: register eq=1, go to DONE.
  - le=1, ge=1 with idx>0: idx decrements, stay in COMPARE.
  - le=0, ge=0 cannot occur. Synthesis treats it as don't-care; the bench flags it as an error.
- DONE: done=1 for exactly one cycle, busy=0, then unconditional move to IDLE. start is ignored in DONE.
- start while busy or in DONE: ignored. Operand registers must not change.
- Latency: accepted start at edge E0; first differing bit at index j.
  - done is high in the cycle after edge E0+(WIDTH-j).
  - MSB differs: 1 compare cycle, done after E1.
  - Equal operands: WIDTH compare cycles, done after E_WIDTH.
- Result flags: exactly one of gt/lt/eq is 1 from the done cycle until the next accepted start. All three are 0 between reset and the first done.
- a and b may change freely after the start edge; only the captured copies are used.
- WIDTH=1: idx is 1 bit wide and stays 0. Compare always completes in 1 cycle.

Decomposition:
- Package serial_cmp_pkg:
  - state encoding constants IDLE=2'd0, COMPARE=2'd1, DONE=2'd2;
  - the cell's le/ge result codes (LT=2'b10, GT=2'b01, EQ=2'b11 as {le,ge}).
- Sub-module bit_le_ge: the 1-bit cell, instantiated once.
  - Inputs a_bit, b_bit; outputs le, ge.
  - Kept separate so it can be verified exhaustively on its own (4 input combinations).
- FSM, counter and operand registers stay in the top module.

Test Plan:
- WIDTH=8; reset, then start with a=8'hA5, b=8'h25 → MSB differs. busy high for 1 cycle, done pulses after E1, gt=1, lt=0, eq=0.
- a=8'h3C, b=8'h3D → differ only at bit 0. busy for 8 cycles, done after E8, lt=1.
- a=8'hFF, b=8'hFF → done after E8, eq=1. Flags stay held over 5 idle cycles with start=0.
- During the previous compare, pulse start with a=8'h00, b=8'hFF at cycle 3 → ignored. Original result delivered, then a fresh start gives lt=1 after E1.
- Assert reset at cycle 4 of an 8-cycle compare → busy, done and flags go 0 immediately (asynchronous). No done pulse follows; the next start operates normally.
- WIDTH=1 build: all four (a,b) pairs → done after E1 each time, with gt/lt/eq matching a>b, a<b, a==b.
